// File: rtl/cp_pkg.sv
// Shared types and constants for the CP hazard controller and its scoreboard.
package cp_pkg;

   localparam int CP_NUM_REGS = 32;
   localparam int CP_ADDR_W   = $clog2(CP_NUM_REGS);

   typedef logic [CP_ADDR_W-1:0] cp_reg_addr_t;

   typedef enum logic {
      HZ_RUN   = 1'b0,
      HZ_DRAIN = 1'b1
   } hz_state_e;

   // x0 is hardwired to zero, so it never carries a dependency.
   function automatic logic cp_reg_tracked(input cp_reg_addr_t addr);
      return addr != '0;
   endfunction

endpackage

// File: rtl/cp_scoreboard.sv
// Per-register pending-write counters with RAW/WAW lookup for the ID stage.
// CP_HAZARD_WB_BYPASS_EN: a source whose last pending write retires this cycle does not hazard.
module cp_scoreboard
   import cp_pkg::*;
#(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rs1_addr,
   input  logic             rs1_use,
   input  logic [4:0]       rs2_addr,
   input  logic             rs2_use,
   input  logic [4:0]       rd_addr,
   input  logic             rd_we,
   input  logic             alloc,
   input  logic             wb_valid,
   input  logic [4:0]       wb_addr,
   input  logic             wb_we,
   output logic             raw_hz,
   output logic             waw_limit,
   output logic             release_ok,
   output logic             release_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Entry 0 is reset and never updated, so lookups of x0 always read zero.
   logic [CNT_W-1:0]       cnt [CP_NUM_REGS];
   logic [CNT_W-1:0]       rs1_cnt, rs2_cnt, rd_cnt, wb_cnt;
   logic                   wb_hit;
   logic                   rs1_hz, rs2_hz;
   logic [CP_NUM_REGS-1:0] up_vec, dn_vec;

   assign rs1_cnt = cnt[rs1_addr];
   assign rs2_cnt = cnt[rs2_addr];
   assign rd_cnt  = cnt[rd_addr];
   assign wb_cnt  = cnt[wb_addr];

   assign wb_hit      = wb_valid & wb_we & cp_reg_tracked(wb_addr);
   assign release_ok  = wb_hit & (wb_cnt != '0);
   assign release_err = wb_hit & (wb_cnt == '0);

   always_comb begin
      rs1_hz = rs1_use & cp_reg_tracked(rs1_addr) & (rs1_cnt != '0);
      rs2_hz = rs2_use & cp_reg_tracked(rs2_addr) & (rs2_cnt != '0);
`ifdef CP_HAZARD_WB_BYPASS_EN
      if (release_ok && (wb_addr == rs1_addr) && (rs1_cnt == CNT_ONE)) begin
         rs1_hz = 1'b0;
      end
      if (release_ok && (wb_addr == rs2_addr) && (rs2_cnt == CNT_ONE)) begin
         rs2_hz = 1'b0;
      end
`endif
      raw_hz    = rs1_hz | rs2_hz;
      waw_limit = rd_we & cp_reg_tracked(rd_addr) & (rd_cnt == CNT_MAX);
   end

   always_comb begin
      up_vec = '0;
      dn_vec = '0;
      if (alloc) begin
         up_vec[rd_addr] = 1'b1;
      end
      if (release_ok) begin
         dn_vec[wb_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < CP_NUM_REGS; r++) begin
            cnt[r] <= '0;
         end
      end else begin
         for (int unsigned r = 1; r < CP_NUM_REGS; r++) begin
            if (up_vec[r] && !dn_vec[r]) begin
               cnt[r] <= cnt[r] + CNT_ONE;
            end else if (dn_vec[r] && !up_vec[r]) begin
               cnt[r] <= cnt[r] - CNT_ONE;
            end
         end
      end
   end

endmodule

// File: rtl/cp_hazard_ctrl.sv
// ID-stage hazard controller: scoreboard-driven stall/issue, in-flight writer count, drain FSM.
// CP_HAZARD_WB_BYPASS_EN (optional) enables same-cycle writeback bypass in cp_scoreboard.
module cp_hazard_ctrl
   import cp_pkg::*;
#(
   parameter int MAX_INFLIGHT = 4,
   parameter int CNT_W        = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              id_valid_i,
   input  logic [4:0]                        id_rs1_addr_i,
   input  logic [4:0]                        id_rs2_addr_i,
   input  logic                              id_rs1_use_i,
   input  logic                              id_rs2_use_i,
   input  logic [4:0]                        id_rd_addr_i,
   input  logic                              id_rd_we_i,
   input  logic                              ex_ready_i,
   input  logic                              wb_valid_i,
   input  logic [4:0]                        wb_rd_addr_i,
   input  logic                              wb_rd_we_i,
   input  logic                              drain_req_i,
   output logic                              stall_id_o,
   output logic                              issue_o,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0] outstanding_o,
   output logic                              drain_done_o,
   output logic                              sb_err_o
);

   localparam int OUT_W = $clog2(MAX_INFLIGHT + 1);
   localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_INFLIGHT);

   hz_state_e        state, state_nxt;
   logic [OUT_W-1:0] outstanding;
   logic             sb_err;
   logic             raw_hz, waw_limit, full;
   logic             alloc, release_ok, release_err;

   cp_scoreboard #(
      .CNT_W (CNT_W)
   ) u_sb (
      .clk         (clk),
      .rst_n       (rst_n),
      .rs1_addr    (id_rs1_addr_i),
      .rs1_use     (id_rs1_use_i),
      .rs2_addr    (id_rs2_addr_i),
      .rs2_use     (id_rs2_use_i),
      .rd_addr     (id_rd_addr_i),
      .rd_we       (id_rd_we_i),
      .alloc       (alloc),
      .wb_valid    (wb_valid_i),
      .wb_addr     (wb_rd_addr_i),
      .wb_we       (wb_rd_we_i),
      .raw_hz      (raw_hz),
      .waw_limit   (waw_limit),
      .release_ok  (release_ok),
      .release_err (release_err)
   );

   assign full          = id_rd_we_i & (outstanding == OUT_MAX);
   assign stall_id_o    = id_valid_i & (raw_hz | waw_limit | full | (state != HZ_RUN));
   assign issue_o       = id_valid_i & ex_ready_i & ~stall_id_o;
   assign alloc         = issue_o & id_rd_we_i & cp_reg_tracked(id_rd_addr_i);
   assign outstanding_o = outstanding;
   assign sb_err_o      = sb_err;

   always_comb begin
      state_nxt    = state;
      drain_done_o = 1'b0;
      unique case (state)
         HZ_RUN: begin
            if (drain_req_i) begin
               state_nxt = HZ_DRAIN;
            end
         end
         HZ_DRAIN: begin
            if (outstanding == '0) begin
               state_nxt    = HZ_RUN;
               drain_done_o = 1'b1;
            end
         end
         default: state_nxt = HZ_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= HZ_RUN;
         outstanding <= '0;
         sb_err      <= 1'b0;
      end else begin
         state <= state_nxt;
         // Simultaneous allocate and release cancel, leaving the count unchanged.
         unique case ({alloc, release_ok})
            2'b10:   outstanding <= outstanding + OUT_W'(1);
            2'b01:   outstanding <= outstanding - OUT_W'(1);
            default: outstanding <= outstanding;
         endcase
         if (release_err) begin
            sb_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cp_hazard_ctrl.sv
// Self-checking bench for cp_hazard_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
module tb_cp_hazard_ctrl;

   localparam int MAX_INFLIGHT = 4;
   localparam int CNT_W        = 2;
   localparam int OUT_W        = $clog2(MAX_INFLIGHT + 1);

   logic             clk;
   logic             rst_n;
   logic             id_valid_i;
   logic [4:0]       id_rs1_addr_i, id_rs2_addr_i;
   logic             id_rs1_use_i, id_rs2_use_i;
   logic [4:0]       id_rd_addr_i;
   logic             id_rd_we_i;
   logic             ex_ready_i;
   logic             wb_valid_i;
   logic [4:0]       wb_rd_addr_i;
   logic             wb_rd_we_i;
   logic             drain_req_i;
   logic             stall_id_o, issue_o, drain_done_o, sb_err_o;
   logic [OUT_W-1:0] outstanding_o;

   cp_hazard_ctrl #(
      .MAX_INFLIGHT (MAX_INFLIGHT),
      .CNT_W        (CNT_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_valid_i    (id_valid_i),
      .id_rs1_addr_i (id_rs1_addr_i),
      .id_rs2_addr_i (id_rs2_addr_i),
      .id_rs1_use_i  (id_rs1_use_i),
      .id_rs2_use_i  (id_rs2_use_i),
      .id_rd_addr_i  (id_rd_addr_i),
      .id_rd_we_i    (id_rd_we_i),
      .ex_ready_i    (ex_ready_i),
      .wb_valid_i    (wb_valid_i),
      .wb_rd_addr_i  (wb_rd_addr_i),
      .wb_rd_we_i    (wb_rd_we_i),
      .drain_req_i   (drain_req_i),
      .stall_id_o    (stall_id_o),
      .issue_o       (issue_o),
      .outstanding_o (outstanding_o),
      .drain_done_o  (drain_done_o),
      .sb_err_o      (sb_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: pending writes per register, in-flight total, sticky error, drain flag.
   int pend [32];
   int outst;
   bit sberr;
   bit in_drain;
   int errors;
   int checks;
   int done_pulses;

`ifdef CP_HAZARD_WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) pend[i] = 0;
      outst    = 0;
      sberr    = 1'b0;
      in_drain = 1'b0;
   endtask

   function automatic bit src_hazard(input logic use_b, input logic [4:0] a, input bit wbrel);
      if (!use_b || a == 5'd0 || pend[a] == 0) return 1'b0;
      if (BYPASS && pend[a] == 1 && wbrel && wb_rd_addr_i == a) return 1'b0;
      return 1'b1;
   endfunction

   // Called at a negedge with inputs already driven; checks outputs, then advances one clock.
   task automatic cycle();
      bit wbrel, wbany, waw, full, e_stall, e_issue, e_done, nxt_drain;
      #1;
      wbany   = wb_valid_i && wb_rd_we_i && wb_rd_addr_i != 5'd0;
      wbrel   = wbany && pend[wb_rd_addr_i] != 0;
      waw     = id_rd_we_i && id_rd_addr_i != 5'd0 && pend[id_rd_addr_i] == (1 << CNT_W) - 1;
      full    = id_rd_we_i && outst == MAX_INFLIGHT;
      e_stall = id_valid_i && (src_hazard(id_rs1_use_i, id_rs1_addr_i, wbrel) ||
                               src_hazard(id_rs2_use_i, id_rs2_addr_i, wbrel) ||
                               waw || full || in_drain);
      e_issue = id_valid_i && ex_ready_i && !e_stall;
      e_done  = in_drain && outst == 0;
      chk("stall", int'(stall_id_o), int'(e_stall));
      chk("issue", int'(issue_o), int'(e_issue));
      chk("drain_done", int'(drain_done_o), int'(e_done));
      chk("outstanding", int'(outstanding_o), outst);
      chk("sb_err", int'(sb_err_o), int'(sberr));
      done_pulses += int'(drain_done_o);
      nxt_drain = in_drain ? (outst != 0) : drain_req_i;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         if (e_issue && id_rd_we_i && id_rd_addr_i != 5'd0) begin
            pend[id_rd_addr_i]++;
            outst++;
         end
         if (wbrel) begin
            pend[wb_rd_addr_i]--;
            outst--;
         end else if (wbany) begin
            sberr = 1'b1;
         end
         in_drain = nxt_drain;
      end
      @(negedge clk);
   endtask

   task automatic idle();
      rst_n         = 1'b1;
      id_valid_i    = 1'b0;
      id_rs1_addr_i = '0;
      id_rs2_addr_i = '0;
      id_rs1_use_i  = 1'b0;
      id_rs2_use_i  = 1'b0;
      id_rd_addr_i  = '0;
      id_rd_we_i    = 1'b0;
      ex_ready_i    = 1'b0;
      wb_valid_i    = 1'b0;
      wb_rd_addr_i  = '0;
      wb_rd_we_i    = 1'b0;
      drain_req_i   = 1'b0;
   endtask

   task automatic set_issue(input int rd);
      id_valid_i   = 1'b1;
      ex_ready_i   = 1'b1;
      id_rd_we_i   = 1'b1;
      id_rd_addr_i = 5'(rd);
   endtask

   task automatic set_wb(input int rd);
      wb_valid_i   = 1'b1;
      wb_rd_we_i   = 1'b1;
      wb_rd_addr_i = 5'(rd);
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      cycle();
      idle();
   endtask

   initial begin
      errors      = 0;
      checks      = 0;
      done_pulses = 0;
      idle();
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      model_reset();

      // Still in reset: valid reads/writes see cleared state, no spurious hazard.
      id_valid_i = 1'b1; ex_ready_i = 1'b1; id_rs1_use_i = 1'b1; id_rs1_addr_i = 5'd3;
      id_rd_we_i = 1'b1; id_rd_addr_i = 5'd3;
      cycle();
      idle();
      #1 chk("reset_outst", int'(outstanding_o), 0);
      chk("reset_sberr", int'(sb_err_o), 0);
      cycle();

      // RAW on x5 until its writeback.
      set_issue(5); cycle();
      idle(); id_valid_i = 1'b1; ex_ready_i = 1'b1; id_rs1_use_i = 1'b1; id_rs1_addr_i = 5'd5;
      #1 chk("raw_stall", int'(stall_id_o), 1);
      cycle(); cycle();
      set_wb(5);
      #1 chk("raw_wb_cycle", int'(stall_id_o), BYPASS ? 0 : 1);
      cycle();
      wb_valid_i = 1'b0; wb_rd_we_i = 1'b0;
      #1 chk("raw_released", int'(stall_id_o), 0);
      cycle();

      // Four writers in flight, fifth stalls on full.
      do_reset();
      for (int r = 1; r <= 4; r++) begin
         set_issue(r); cycle();
      end
      set_issue(6);
      #1 chk("full_stall", int'(stall_id_o), 1);
      chk("full_outst", int'(outstanding_o), 4);
      cycle();
      set_wb(1); cycle();
      wb_valid_i = 1'b0; wb_rd_we_i = 1'b0;
      #1 chk("full_issue_after_wb", int'(issue_o), 1);
      cycle();

      // WAW counter limit on x7; x0 never hazards.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         set_issue(7); cycle();
      end
      set_issue(7);
      #1 chk("waw_stall", int'(stall_id_o), 1);
      cycle();
      idle(); set_issue(0); id_rs1_use_i = 1'b1; id_rs2_use_i = 1'b1;
      #1 chk("x0_no_stall", int'(stall_id_o), 0);
      chk("x0_issue", int'(issue_o), 1);
      cycle();
      idle();
      #1 chk("x0_outst", int'(outstanding_o), 3);
      cycle();

      // Same-cycle issue and writeback to x9.
      do_reset();
      set_issue(9); cycle();
      set_issue(9); set_wb(9); cycle();
      idle();
      #1 chk("x9_net_outst", int'(outstanding_o), 1);
      cycle();
      set_wb(9); cycle();
      idle();
      #1 chk("x9_clean_err", int'(sb_err_o), 0);
      cycle();

      // Drain with two writers outstanding.
      do_reset();
      set_issue(2); cycle();
      set_issue(3); cycle();
      idle(); drain_req_i = 1'b1; cycle();
      idle(); id_valid_i = 1'b1; ex_ready_i = 1'b1;
      #1 chk("drain_stall", int'(stall_id_o), 1);
      done_pulses = 0;
      cycle();
      drain_req_i = 1'b1; cycle();
      drain_req_i = 1'b0;
      set_wb(2); cycle();
      set_wb(3); cycle();
      wb_valid_i = 1'b0; wb_rd_we_i = 1'b0;
      cycle(); cycle(); cycle();
      chk("drain_pulses", done_pulses, 1);
      #1 chk("drain_back_run", int'(issue_o), 1);
      cycle();

      // Drain requested with nothing in flight.
      idle(); drain_req_i = 1'b1; cycle();
      idle();
      #1 chk("drain_empty_done", int'(drain_done_o), 1);
      cycle();

      // Spurious release, then reset mid-drain.
      do_reset();
      set_wb(12); cycle();
      idle();
      #1 chk("sberr_set", int'(sb_err_o), 1);
      cycle(); cycle();
      chk("sberr_sticky", int'(sb_err_o), 1);
      set_issue(4); cycle();
      idle(); drain_req_i = 1'b1; cycle();
      idle(); rst_n = 1'b0; cycle();
      idle(); id_valid_i = 1'b1; ex_ready_i = 1'b1; id_rs1_use_i = 1'b1; id_rs1_addr_i = 5'd4;
      #1 chk("rst_drain_outst", int'(outstanding_o), 0);
      chk("rst_drain_sberr", int'(sb_err_o), 0);
      chk("rst_drain_issue", int'(issue_o), 1);
      cycle();

      // Randomized traffic on a small register window to provoke collisions.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         int q[$];
         idle();
         if ($urandom_range(199) == 0) rst_n = 1'b0;
         id_valid_i    = ($urandom_range(3) != 0);
         ex_ready_i    = ($urandom_range(3) != 0);
         id_rs1_addr_i = 5'($urandom_range(7));
         id_rs2_addr_i = 5'($urandom_range(7));
         id_rs1_use_i  = 1'($urandom_range(1));
         id_rs2_use_i  = 1'($urandom_range(1));
         id_rd_addr_i  = 5'($urandom_range(7));
         id_rd_we_i    = 1'($urandom_range(1));
         drain_req_i   = ($urandom_range(39) == 0);
         if ($urandom_range(2) != 0) begin
            for (int i = 1; i < 32; i++) if (pend[i] > 0) q.push_back(i);
            wb_valid_i = 1'b1;
            wb_rd_we_i = ($urandom_range(7) != 0);
            if (q.size() > 0 && $urandom_range(15) != 0)
               wb_rd_addr_i = 5'(q[$urandom_range(q.size() - 1)]);
            else
               wb_rd_addr_i = 5'($urandom_range(7));
         end
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cp_hazard_ctrl.md
CP_HAZARD_CTRL -- requirements
Module: cp_hazard_ctrl

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 4: maximum issued-but-not-written-back register-writing instructions.
REQ-002 SHALL have parameter CNT_W, default 2: width of each per-register pending counter.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 id_valid_i  in  1  ID holds a valid decoded instruction.
REQ-006 id_rs1_addr_i, id_rs2_addr_i  in  5 each  source register addresses.
REQ-007 id_rs1_use_i, id_rs2_use_i  in  1 each  instruction actually reads rs1/rs2.
REQ-008 id_rd_addr_i  in  5  destination address; id_rd_we_i  in  1  instruction writes rd.
REQ-009 ex_ready_i  in  1  EX accepts an instruction this cycle.
REQ-010 wb_valid_i  in  1  writeback event; wb_rd_addr_i  in  5; wb_rd_we_i  in  1  event releases wb_rd_addr_i.
REQ-011 drain_req_i  in  1  single-cycle request to empty the pipeline (fence/CSR).
REQ-012 stall_id_o  out  1  ID must hold its instruction.
REQ-013 issue_o  out  1  instruction transfers ID->EX this cycle.
REQ-014 outstanding_o  out  $clog2(MAX_INFLIGHT+1)  in-flight writer count.
REQ-015 drain_done_o  out  1  one-cycle pulse when a drain completes.
REQ-016 sb_err_o  out  1  sticky: release seen for a register with zero pending.

Function
REQ-017 SHALL keep one CNT_W-bit pending counter per register 1..31; x0 never tracked, never hazards.
REQ-018 RAW hazard SHALL be true when a used source (use=1, addr!=0) has pending counter !=0.
REQ-019 WAW limit SHALL be true when id_rd_we_i=1, rd!=0 and rd's counter equals 2^CNT_W-1.
REQ-020 Full SHALL be true when id_rd_we_i=1 and outstanding_o==MAX_INFLIGHT.
REQ-021 stall_id_o SHALL equal id_valid_i AND (RAW OR WAW limit OR full OR state!=RUN), combinationally.
REQ-022 issue_o SHALL equal id_valid_i AND ex_ready_i AND NOT stall_id_o.
REQ-023 On issue_o with id_rd_we_i=1 and rd!=0: rd counter +1 and outstanding +1 next cycle.
REQ-024 On wb_valid_i AND wb_rd_we_i with addr!=0 and counter!=0: counter -1, outstanding -1 next cycle.
REQ-025 Issue and release to the same register in one cycle SHALL leave that counter unchanged; outstanding likewise nets to zero.
REQ-026 Release with counter==0 SHALL change no counter, SHALL set sb_err_o until reset.
REQ-027 Flushed instructions SHALL still be released via wb_valid_i/wb_rd_we_i; no separate flush port.
REQ-028 FSM states RUN, DRAIN: RUN->DRAIN on drain_req_i; DRAIN->RUN when outstanding_o==0, asserting drain_done_o that same cycle.
REQ-029 drain_req_i in DRAIN SHALL be ignored; drain_req_i with outstanding_o==0 SHALL enter DRAIN and pulse drain_done_o next cycle.

Reset
REQ-030 rst_n=0 at a clock edge SHALL clear all counters, outstanding_o, sb_err_o, drain_done_o and set state RUN, regardless of in-flight activity.
REQ-031 During reset stall_id_o and issue_o SHALL follow REQ-021/022 with cleared state (no spurious hazard).

Configuration
REQ-032 Macro CP_HAZARD_WB_BYPASS_EN: when defined, a RAW source whose counter==1 and is released this same cycle SHALL NOT cause a stall (write-through register file).
REQ-033 Without CP_HAZARD_WB_BYPASS_EN, such a source SHALL stall one cycle until the counter reads 0.

Structure
REQ-034 Shared package cp_pkg SHALL hold the FSM state enum (HZ_RUN, HZ_DRAIN) and constant CP_NUM_REGS=32.
REQ-035 Sub-module cp_scoreboard SHALL contain the per-register counters and RAW/WAW lookup; FSM, outstanding counter and stall/issue logic live in cp_hazard_ctrl.

Verification
REQ-036 Issue rd=x5, next cycle ID reads rs1=x5 -> stall_id_o=1 until wb x5; stall drop same cycle (bypass) or next cycle (no bypass).
REQ-037 Four writers x1..x4 outstanding, fifth writer x6 -> stall_id_o=1, outstanding_o=4; one wb -> issue_o=1 next cycle.
REQ-038 Three issues to x7 (CNT_W=2), fourth to x7 -> stalled by WAW limit; read of x0 with x0 "writes" -> never stalls.
REQ-039 Issue and wb to x9 in same cycle with counter=1 -> counter stays 1, outstanding_o unchanged.
REQ-040 drain_req_i with 2 outstanding -> stall_id_o=1, drain_done_o pulses exactly once after second wb, state RUN.
REQ-041 wb to x12 with no pending -> sb_err_o=1 sticky; rst_n=0 mid-drain -> all counters 0, RUN, sb_err_o=0.
